// File: rtl/bf_envelope_compress.sv
// rtl/bf_envelope_compress.sv - rectify, moving-average envelope and log compression of one scan line
// Emits one 8-bit pixel per accepted sample through a small show-ahead output FIFO.
module bf_envelope_compress #(
    parameter int IN_W       = 18,
    parameter int AVG_LOG2   = 2,
    parameter int SAMPLES    = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   line_start,
    input  logic                   in_valid,
    input  logic signed [IN_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_pixel,
    output logic                   out_last,
    output logic                   overflow,
    output logic [1:0]             state
);
    localparam int A_W   = IN_W - 1;
    localparam int S_W   = A_W + AVG_LOG2;
    localparam int WIN   = 1 << AVG_LOG2;
    localparam int CNT_W = $clog2(SAMPLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES - 1);
    localparam logic [IN_W-1:0]  MIN_VAL  = {1'b1, {(IN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

    state_t state_q, state_d;
    logic   accept;

    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
    logic [A_W-1:0]   s1_a_q, s1_a_d;
    logic [A_W-1:0]   win_q [WIN];
    logic [A_W-1:0]   win_d [WIN];
    logic [S_W-1:0]   sum_q, sum_d;
    logic [7:0]       s3_pixel_q, s3_pixel_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, pix_cnt_q, pix_cnt_d;
    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [8:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;

    logic             fifo_empty, fifo_full, pop, push, push_ok, drop, drained;
    logic [IN_W-1:0]  neg_data;
    logic [A_W-1:0]   a_rect, env;
    logic [4:0]       lead;
    logic [A_W+2:0]   env_ext;
    logic [7:0]       pixel;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop        = !fifo_empty && out_ready;
    // Pixels emerging in a line_start cycle belong to the aborted line.
    assign push       = s3_valid_q && !line_start;
    assign push_ok    = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;
    assign drained    = !s1_valid_q && !s2_valid_q && !s3_valid_q && fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (line_start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     if (accept && acc_cnt_q == LAST_IDX) state_d = FLUSH;
                FLUSH:   if (drained) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        accept = (state_q == RUN) && in_valid && !line_start;
        state  = state_q;
    end

    always_comb begin
        neg_data = ~in_data + IN_W'(1);
        if (!in_data[IN_W-1])      a_rect = in_data[A_W-1:0];
        else if (in_data == MIN_VAL) a_rect = {A_W{1'b1}};
        else                       a_rect = neg_data[A_W-1:0];

        env  = sum_q[S_W-1:AVG_LOG2];
        lead = 5'd0;
        for (int i = 0; i < A_W; i++) begin
            if (env[i]) lead = 5'(i);
        end
        // Shifting by the leading-one index leaves the three bits below it, zero-filled from the right.
        env_ext = {env, 3'b000} >> lead;
        pixel   = (env == '0) ? 8'd0 : {lead + 5'd1, env_ext[2:0]};
    end

    always_comb begin
        s1_valid_d = accept;
        s1_a_d     = a_rect;
        s2_valid_d = s1_valid_q;
        s3_valid_d = s2_valid_q;
        s3_pixel_d = pixel;
        win_d      = win_q;
        sum_d      = sum_q;
        acc_cnt_d  = accept ? acc_cnt_q + CNT_W'(1) : acc_cnt_q;
        pix_cnt_d  = push ? pix_cnt_q + CNT_W'(1) : pix_cnt_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;
        overflow_d = overflow_q || drop;
        if (s1_valid_q) begin
            for (int i = WIN - 1; i > 0; i--) win_d[i] = win_q[i-1];
            win_d[0] = s1_a_q;
            sum_d    = sum_q + S_W'(s1_a_q) - S_W'(win_q[WIN-1]);
        end
        if (push_ok) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = {pix_cnt_q == LAST_IDX, s3_pixel_q};
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (line_start) begin
            s2_valid_d = 1'b0;
            s3_valid_d = 1'b0;
            win_d      = '{default: '0};
            sum_d      = '0;
            acc_cnt_d  = '0;
            pix_cnt_d  = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_a_q     <= '0;
            win_q      <= '{default: '0};
            sum_q      <= '0;
            s3_pixel_q <= '0;
            acc_cnt_q  <= '0;
            pix_cnt_q  <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            s1_a_q     <= s1_a_d;
            win_q      <= win_d;
            sum_q      <= sum_d;
            s3_pixel_q <= s3_pixel_d;
            acc_cnt_q  <= acc_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_pixel = mem_q[rd_ptr_q[PTR_W-1:0]][7:0];
    assign out_last  = mem_q[rd_ptr_q[PTR_W-1:0]][8];
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_bf_envelope_compress.sv
// tb/tb_bf_envelope_compress.sv - directed bench with cycle-level scoreboard for bf_envelope_compress
module tb_bf_envelope_compress;
    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              line_start = 1'b0;
    logic              in_valid = 1'b0;
    logic signed [17:0] in_data = '0;
    logic              out_ready = 1'b0;
    logic              out_valid, out_last, overflow;
    logic [7:0]        out_pixel;
    logic [1:0]        state;

    bf_envelope_compress dut (
        .clk(clk), .reset(reset), .line_start(line_start), .in_valid(in_valid),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_last(out_last), .overflow(overflow), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [8:0] v;
    } pend_t;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    pend_t      pend[$];
    logic [8:0] mq[$];
    logic       m_ovf = 1'b0;
    int         pops = 0;
    int         lasts = 0;
    bit         tog = 1'b0;
    bit         m_run = 1'b0;
    int         m_cnt = 0;
    int         h[4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] px(input int e);
        int p, m;
        if (e == 0) return 8'd0;
        p = 0;
        for (int i = 0; i < 17; i++) if (((e >> i) & 1) == 1) p = i;
        m = ((e * 8) >> p) & 7;
        return 8'((p + 1) * 8 + m);
    endfunction

    // Model FIFO: pop first, then push if room, else flag overflow.
    always @(negedge clk) begin
        if (!reset) begin
            mq.delete();
            pend.delete();
            m_ovf = 1'b0;
        end else begin
            chk("out_valid", out_valid, mq.size() != 0);
            chk("overflow", overflow, m_ovf);
            if (line_start) begin
                mq.delete();
                pend.delete();
                m_ovf = 1'b0;
            end else begin
                if (out_valid && out_ready && mq.size() > 0) begin
                    chk("pixel", {out_last, out_pixel}, mq.pop_front());
                    pops++;
                    if (out_last) lasts++;
                end
                if (pend.size() > 0 && pend[0].due == cyc + 1) begin
                    pend_t pe;
                    pe = pend.pop_front();
                    if (mq.size() < 4) mq.push_back(pe.v);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    task automatic drive(input bit ls, input bit v, input int d);
        int a, sum;
        pend_t pe;
        line_start = ls;
        in_valid   = v;
        in_data    = 18'(d);
        if (ls) begin
            m_run = 1'b1;
            m_cnt = 0;
            for (int i = 0; i < 4; i++) h[i] = 0;
        end else if (m_run && v) begin
            a = (d < 0) ? -d : d;
            if (a > 131071) a = 131071;
            for (int i = 3; i > 0; i--) h[i] = h[i-1];
            h[0] = a;
            sum = h[0] + h[1] + h[2] + h[3];
            pe.due = cyc + 4;
            pe.v   = {m_cnt == 255, px(sum / 4)};
            pend.push_back(pe);
            m_cnt++;
            if (m_cnt == 256) m_run = 1'b0;
        end
        if (tog) out_ready = ~out_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && state != 2'd0; i++) drive(0, 0, 0);
        chk(tag, state, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_state", state, 0);
        chk("rst_pixel", {out_last, out_pixel}, 0);
        reset     = 1'b1;
        out_ready = 1'b1;
        drive(0, 1, 500);
        chk("idle_ignores_input", state, 0);

        // Constant 1000: ramp then steady, single out_last.
        drive(1, 1, 1000);
        chk("t2_run", state, 1);
        pops = 0; lasts = 0;
        for (int i = 0; i < 256; i++) drive(0, 1, 1000);
        chk("t2_flush", state, 2);
        wait_idle("t2_idle");
        chk("t2_pops", pops, 256);
        chk("t2_lasts", lasts, 1);

        // Saturating negative full scale, then all zero.
        drive(1, 0, 0);
        for (int i = 0; i < 256; i++) drive(0, 1, -131072);
        wait_idle("t3a_idle");
        drive(1, 0, 0);
        for (int i = 0; i < 256; i++) drive(0, 1, 0);
        wait_idle("t3b_idle");

        // Asynchronous reset in the middle of a line.
        drive(1, 0, 0);
        for (int i = 0; i < 50; i++) drive(0, 1, 7000 - i * 300);
        reset = 1'b0;
        m_run = 1'b0;
        #1;
        chk("t1_out_valid", out_valid, 0);
        chk("t1_overflow", overflow, 0);
        chk("t1_state", state, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) drive(0, 1, 500);
        chk("t1_stays_idle", state, 0);
        chk("t1_empty", out_valid, 0);

        // Backpressure: four stored, rest dropped, overflow sticky.
        out_ready = 1'b0;
        drive(1, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 1, 300 * (i + 1));
        repeat (3) drive(0, 0, 0);
        chk("t4_overflow", overflow, 1);
        chk("t4_valid", out_valid, 1);
        out_ready = 1'b1;
        pops = 0;
        repeat (6) drive(0, 0, 0);
        chk("t4_pops", pops, 4);
        chk("t4_overflow_sticky", overflow, 1);

        // Abort after 100 samples, then full line.
        drive(1, 0, 0);
        chk("t5_overflow_cleared", overflow, 0);
        for (int i = 0; i < 100; i++) drive(0, 1, int'($urandom_range(0, 262143)) - 131072);
        drive(1, 1, 1234);
        chk("t5_state", state, 1);
        chk("t5_fifo_emptied", out_valid, 0);
        pops = 0; lasts = 0;
        for (int i = 0; i < 256; i++) drive(0, 1, int'($urandom_range(0, 262143)) - 131072);
        wait_idle("t5_idle");
        chk("t5_pops", pops, 256);
        chk("t5_lasts", lasts, 1);

        // out_ready toggling every cycle with continuous input.
        tog = 1'b1;
        drive(1, 0, 0);
        for (int i = 0; i < 256; i++) drive(0, 1, int'($urandom_range(0, 262143)) - 131072);
        wait_idle("t6_idle");
        tog = 1'b0;
        chk("t6_model_drained", mq.size(), 0);
        chk("t6_overflow", overflow, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
